// File: rtl/gbus_pkg.sv
// rtl/gbus_pkg.sv - shared gbus field widths and write record type
package gbus_pkg;

    localparam int HEAD_SRAM_BIAS_WIDTH = 2;
    localparam int BUS_CORE_ADDR_WIDTH  = 4;
    localparam int BUS_CMEM_ADDR_WIDTH  = 13;
    localparam int GBUS_DATA_WIDTH      = 32;
    localparam int GBUS_ADDR_WIDTH      = HEAD_SRAM_BIAS_WIDTH + BUS_CORE_ADDR_WIDTH
                                          + BUS_CMEM_ADDR_WIDTH;

    typedef struct packed {
        logic [GBUS_ADDR_WIDTH-1:0] addr;
        logic [GBUS_DATA_WIDTH-1:0] data;
    } gbus_wr_t;

endpackage

// File: rtl/gbus_sync_fifo.sv
// rtl/gbus_sync_fifo.sv - show-ahead sync FIFO that drops pushes when full
module gbus_sync_fifo #(
    parameter int WIDTH = 51,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             overflow_pulse
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_pop         = pop & ~empty;
    assign do_push        = push & (~full | do_pop);
    assign overflow_pulse = push & full & ~do_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/head_gbus_arbiter.sv
// rtl/head_gbus_arbiter.sv - per-core gbus write FIFOs drained round-robin onto one registered bus
module head_gbus_arbiter #(
    parameter int CORE_NUM        = 8,
    parameter int GBUS_ADDR_WIDTH = gbus_pkg::GBUS_ADDR_WIDTH,
    parameter int GBUS_DATA_WIDTH = gbus_pkg::GBUS_DATA_WIDTH,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CORE_NUM*GBUS_ADDR_WIDTH-1:0] core_gbus_addr,
    input  logic [CORE_NUM-1:0]                 core_gbus_wen,
    input  logic [CORE_NUM*GBUS_DATA_WIDTH-1:0] core_gbus_wdata,
    output logic [GBUS_ADDR_WIDTH-1:0]          head_gbus_addr,
    output logic                                head_gbus_wen,
    output logic [GBUS_DATA_WIDTH-1:0]          head_gbus_wdata,
    input  logic                                err_clear,
    output logic [CORE_NUM-1:0]                 fifo_overflow,
    output logic                                busy
);

    localparam int PW = $clog2(CORE_NUM);
    localparam int EW = GBUS_ADDR_WIDTH + GBUS_DATA_WIDTH;

    logic [EW-1:0]       fifo_dout [CORE_NUM];
    logic [CORE_NUM-1:0] fifo_empty;
    logic [CORE_NUM-1:0] fifo_full_unused;
    logic [CORE_NUM-1:0] fifo_ovf;
    logic [CORE_NUM-1:0] grant_vec;
    logic                grant_any;
    logic [PW-1:0]       grant_idx;
    logic [PW-1:0]       rr_ptr;
    logic [EW-1:0]       head_entry;

    for (genvar i = 0; i < CORE_NUM; i++) begin : g_fifo
        gbus_sync_fifo #(
            .WIDTH (EW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk            (clk),
            .rst            (rst),
            .push           (core_gbus_wen[i]),
            .pop            (grant_vec[i]),
            .din            ({core_gbus_addr[i*GBUS_ADDR_WIDTH +: GBUS_ADDR_WIDTH],
                              core_gbus_wdata[i*GBUS_DATA_WIDTH +: GBUS_DATA_WIDTH]}),
            .dout           (fifo_dout[i]),
            .full           (fifo_full_unused[i]),
            .empty          (fifo_empty[i]),
            .overflow_pulse (fifo_ovf[i])
        );
    end

    // First non-empty FIFO at or above rr_ptr; the PW-bit sum wraps modulo CORE_NUM.
    always_comb begin
        logic [PW-1:0] cand;
        cand      = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < CORE_NUM; k++) begin
            cand = rr_ptr + PW'(k);
            if (!grant_any && !fifo_empty[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign grant_vec  = grant_any ? (CORE_NUM'(1) << grant_idx) : '0;
    assign head_entry = fifo_dout[grant_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr          <= '0;
            head_gbus_wen   <= 1'b0;
            head_gbus_addr  <= '0;
            head_gbus_wdata <= '0;
            fifo_overflow   <= '0;
        end else begin
            head_gbus_wen <= grant_any;
            if (grant_any) begin
                head_gbus_addr  <= head_entry[EW-1 -: GBUS_ADDR_WIDTH];
                head_gbus_wdata <= head_entry[GBUS_DATA_WIDTH-1:0];
                rr_ptr          <= grant_idx + PW'(1);
            end else begin
                head_gbus_addr  <= '0;
                head_gbus_wdata <= '0;
            end
            fifo_overflow <= (err_clear ? '0 : fifo_overflow) | fifo_ovf;
        end
    end

    // FIFO empties and the output strobe are all flops, so this matches the post-edge state.
    assign busy = (~&fifo_empty) | head_gbus_wen;

endmodule

// File: tb/tb_head_gbus_arbiter.sv
// tb/tb_head_gbus_arbiter.sv - directed vector bench for head_gbus_arbiter
module tb_head_gbus_arbiter;
    import gbus_pkg::*;

    localparam int N  = 8;
    localparam int AW = 19;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*AW-1:0] core_gbus_addr = '0;
    logic [N-1:0]    core_gbus_wen = '0;
    logic [N*DW-1:0] core_gbus_wdata = '0;
    logic [AW-1:0]   head_gbus_addr;
    logic            head_gbus_wen;
    logic [DW-1:0]   head_gbus_wdata;
    logic            err_clear = 1'b0;
    logic [N-1:0]    fifo_overflow;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    head_gbus_arbiter #(
        .CORE_NUM        (N),
        .GBUS_ADDR_WIDTH (AW),
        .GBUS_DATA_WIDTH (DW),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .core_gbus_addr  (core_gbus_addr),
        .core_gbus_wen   (core_gbus_wen),
        .core_gbus_wdata (core_gbus_wdata),
        .head_gbus_addr  (head_gbus_addr),
        .head_gbus_wen   (head_gbus_wen),
        .head_gbus_wdata (head_gbus_wdata),
        .err_clear       (err_clear),
        .fifo_overflow   (fifo_overflow),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] wen;
        logic [7:0] tag;
        logic       clr;
        int         exp_core;
        logic [7:0] exp_tag;
        logic       exp_busy;
        logic [7:0] exp_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic gbus_wr_t mk_wr(input int core, input logic [7:0] tag);
        gbus_wr_t r;
        r.addr = {2'b00, 4'(core), 5'b0, tag};
        r.data = {tag, 16'h0, 8'(core)};
        return r;
    endfunction

    function automatic void add(input logic r, input logic [7:0] w, input logic [7:0] t,
                                input logic c, input int ec, input logic [7:0] et,
                                input logic eb, input logic [7:0] eo);
        vec_t v;
        v.rst = r; v.wen = w; v.tag = t; v.clr = c;
        v.exp_core = ec; v.exp_tag = et; v.exp_busy = eb; v.exp_ovf = eo;
        vecs.push_back(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_row(input int idx, input vec_t v);
        gbus_wr_t w;
        rst           = v.rst;
        err_clear     = v.clr;
        core_gbus_wen = v.wen;
        for (int i = 0; i < N; i++) begin
            w = mk_wr(i, v.tag);
            core_gbus_addr[i*AW +: AW]  = w.addr;
            core_gbus_wdata[i*DW +: DW] = w.data;
        end
        tick();
        if (v.exp_core < 0) begin
            check($sformatf("row%0d wen", idx), 64'(head_gbus_wen), 64'(0));
            check($sformatf("row%0d addr", idx), 64'(head_gbus_addr), 64'(0));
            check($sformatf("row%0d data", idx), 64'(head_gbus_wdata), 64'(0));
        end else begin
            w = mk_wr(v.exp_core, v.exp_tag);
            check($sformatf("row%0d wen", idx), 64'(head_gbus_wen), 64'(1));
            check($sformatf("row%0d addr", idx), 64'(head_gbus_addr), 64'(w.addr));
            check($sformatf("row%0d data", idx), 64'(head_gbus_wdata), 64'(w.data));
        end
        check($sformatf("row%0d busy", idx), 64'(busy), 64'(v.exp_busy));
        check($sformatf("row%0d ovf", idx), 64'(fifo_overflow), 64'(v.exp_ovf));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int seen0[$];
        int total;
        int cyc;
        logic [31:0] seen_packed;

        // reset state
        tick(); tick();
        rst = 1'b0;
        check("reset wen", 64'(head_gbus_wen), 64'(0));
        check("reset addr", 64'(head_gbus_addr), 64'(0));
        check("reset data", 64'(head_gbus_wdata), 64'(0));
        check("reset ovf", 64'(fifo_overflow), 64'(0));
        check("reset busy", 64'(busy), 64'(0));

        // single write latency from core 3
        core_gbus_addr[3*AW +: AW]  = 19'h06005;
        core_gbus_wdata[3*DW +: DW] = 32'hDEADBEEF;
        core_gbus_wen = 8'h08;
        tick();
        core_gbus_wen = 8'h00;
        check("single c1 wen", 64'(head_gbus_wen), 64'(0));
        check("single c1 busy", 64'(busy), 64'(1));
        tick();
        check("single c2 wen", 64'(head_gbus_wen), 64'(1));
        check("single c2 addr", 64'(head_gbus_addr), 64'h06005);
        check("single c2 data", 64'(head_gbus_wdata), 64'hDEADBEEF);
        check("single c2 busy", 64'(busy), 64'(1));
        tick();
        check("single c3 wen", 64'(head_gbus_wen), 64'(0));
        check("single c3 addr", 64'(head_gbus_addr), 64'(0));
        check("single c3 data", 64'(head_gbus_wdata), 64'(0));
        check("single c3 busy", 64'(busy), 64'(0));

        // all cores at once drain in index order
        add(1, 8'h00, 8'h00, 0, -1, 8'h00, 0, 8'h00);
        add(0, 8'hFF, 8'h00, 0, -1, 8'h00, 1, 8'h00);
        for (int k = 0; k < 8; k++) add(0, 8'h00, 8'h00, 0, k, 8'h00, 1, 8'h00);
        add(0, 8'h00, 8'h00, 0, -1, 8'h00, 0, 8'h00);

        // cores 1 and 5 interleave
        add(1, 8'h00, 8'h00, 0, -1, 8'h00, 0, 8'h00);
        add(0, 8'h22, 8'h00, 0, -1, 8'h00, 1, 8'h00);
        add(0, 8'h22, 8'h01, 0,  1, 8'h00, 1, 8'h00);
        add(0, 8'h22, 8'h02, 0,  5, 8'h00, 1, 8'h00);
        add(0, 8'h00, 8'h00, 0,  1, 8'h01, 1, 8'h00);
        add(0, 8'h00, 8'h00, 0,  5, 8'h01, 1, 8'h00);
        add(0, 8'h00, 8'h00, 0,  1, 8'h02, 1, 8'h00);
        add(0, 8'h00, 8'h00, 0,  5, 8'h02, 1, 8'h00);
        add(0, 8'h00, 8'h00, 0, -1, 8'h00, 0, 8'h00);

        // core 2 full, popped and pushed together; next unpopped push drops (tag 7)
        add(1, 8'h00, 8'h00, 0, -1, 8'h00, 0, 8'h00);
        add(0, 8'h07, 8'h00, 0, -1, 8'h00, 1, 8'h00);
        add(0, 8'h07, 8'h01, 0,  0, 8'h00, 1, 8'h00);
        add(0, 8'h07, 8'h02, 0,  1, 8'h00, 1, 8'h00);
        add(0, 8'h03, 8'h03, 0,  2, 8'h00, 1, 8'h00);
        add(0, 8'h04, 8'h04, 0,  0, 8'h01, 1, 8'h00);
        add(0, 8'h04, 8'h05, 0,  1, 8'h01, 1, 8'h00);
        add(0, 8'h04, 8'h06, 0,  2, 8'h01, 1, 8'h00);
        add(0, 8'h04, 8'h07, 0,  0, 8'h02, 1, 8'h04);
        add(0, 8'h00, 8'h00, 0,  1, 8'h02, 1, 8'h04);
        add(0, 8'h00, 8'h00, 0,  2, 8'h02, 1, 8'h04);
        add(0, 8'h00, 8'h00, 0,  0, 8'h03, 1, 8'h04);
        add(0, 8'h00, 8'h00, 0,  1, 8'h03, 1, 8'h04);
        add(0, 8'h00, 8'h00, 0,  2, 8'h04, 1, 8'h04);
        add(0, 8'h00, 8'h00, 0,  2, 8'h05, 1, 8'h04);
        add(0, 8'h00, 8'h00, 0,  2, 8'h06, 1, 8'h04);
        add(0, 8'h00, 8'h00, 0, -1, 8'h00, 0, 8'h04);

        // reset with 10 writes queued, then fresh latency and core 0 priority
        add(1, 8'h00, 8'h00, 0, -1, 8'h00, 0, 8'h00);
        add(0, 8'hFF, 8'h30, 0, -1, 8'h00, 1, 8'h00);
        add(0, 8'h07, 8'h31, 0,  0, 8'h30, 1, 8'h00);
        add(1, 8'h00, 8'h00, 0, -1, 8'h00, 0, 8'h00);
        for (int k = 0; k < 3; k++) add(0, 8'h00, 8'h00, 0, -1, 8'h00, 0, 8'h00);
        add(0, 8'h81, 8'h40, 0, -1, 8'h00, 1, 8'h00);
        add(0, 8'h00, 8'h00, 0,  0, 8'h40, 1, 8'h00);
        add(0, 8'h00, 8'h00, 0,  7, 8'h40, 1, 8'h00);
        add(0, 8'h00, 8'h00, 0, -1, 8'h00, 0, 8'h00);

        // core 0 starved behind cores 1-7; tag 0x15 drops while err_clear is high
        add(1, 8'h00, 8'h00, 0, -1, 8'h00, 0, 8'h00);
        add(0, 8'hFE, 8'h00, 0, -1, 8'h00, 1, 8'h00);
        add(0, 8'hFE, 8'h01, 0,  1, 8'h00, 1, 8'h00);
        add(0, 8'hFE, 8'h02, 0,  2, 8'h00, 1, 8'h00);
        add(0, 8'hFE, 8'h03, 0,  3, 8'h00, 1, 8'h00);
        add(0, 8'h01, 8'h10, 0,  4, 8'h00, 1, 8'h00);
        add(0, 8'h01, 8'h11, 0,  5, 8'h00, 1, 8'h00);
        add(0, 8'h01, 8'h12, 0,  6, 8'h00, 1, 8'h00);
        add(0, 8'h01, 8'h13, 0,  7, 8'h00, 1, 8'h00);
        add(0, 8'h01, 8'h14, 0,  0, 8'h10, 1, 8'h00);
        add(0, 8'h01, 8'h15, 1,  1, 8'h01, 1, 8'h01);
        add(0, 8'h00, 8'h00, 0,  2, 8'h01, 1, 8'h01);

        foreach (vecs[i]) apply_row(i, vecs[i]);

        total = 0;
        cyc   = 0;
        while (busy && cyc < 100) begin
            tick();
            cyc++;
            if (head_gbus_wen) begin
                total++;
                if (head_gbus_wdata[7:0] == 8'd0) seen0.push_back(int'(head_gbus_wdata[31:24]));
            end
        end
        check("drain idle", 64'(busy), 64'(0));
        check("drain count", 64'(total), 64'(23));
        check("drain core0 n", 64'(seen0.size()), 64'(4));
        seen_packed = '0;
        for (int i = 0; i < seen0.size() && i < 4; i++) seen_packed = {seen_packed[23:0], 8'(seen0[i])};
        check("drain core0 order", 64'(seen_packed), 64'h11121314);
        check("ovf held", 64'(fifo_overflow), 64'h01);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("ovf cleared", 64'(fifo_overflow), 64'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/head_gbus_arbiter.md
Name: head_gbus_arbiter

Overview:
Head-level collector that sits directly downstream of every core's out_gbus write port (addr/wen/wdata) and upstream of the cores' shared in_gbus.
Each core's writes are buffered in a per-core FIFO, because out_gbus has no backpressure. The FIFOs are drained one write per cycle onto a single registered bus using round-robin arbitration.
Sticky overflow flags report dropped writes.

Parameters:
CORE_NUM, 8, number of cores on the head; power of two, at least 2.
GBUS_ADDR_WIDTH, 19, gbus address width: HEAD_SRAM_BIAS 2 + BUS_CORE_ADDR 4 + BUS_CMEM_ADDR 13 bits.
GBUS_DATA_WIDTH, 32, gbus data width.
FIFO_DEPTH, 4, entries per core FIFO; power of two, at least 2.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
core_gbus_addr  in  CORE_NUM*GBUS_ADDR_WIDTH  core i's address in slice [i*W +: W]
core_gbus_wen  in  CORE_NUM  per-core write strobe; one write per asserted cycle
core_gbus_wdata  in  CORE_NUM*GBUS_DATA_WIDTH  per-core write data
head_gbus_addr  out  GBUS_ADDR_WIDTH  arbitrated address, registered
head_gbus_wen  out  1  arbitrated write strobe, registered
head_gbus_wdata  out  GBUS_DATA_WIDTH  arbitrated data, registered
err_clear  in  1  clears all sticky overflow flags
fifo_overflow  out  CORE_NUM  sticky per-core drop flag
busy  out  1  high while any FIFO is non-empty or head_gbus_wen is high

Behaviour:
- Reset (rst sampled high at a posedge):
  - all FIFOs are emptied; pointers and counts go to 0.
  - RR pointer goes to 0, meaning core 0 has highest priority next.
  - head_gbus_addr, head_gbus_wen, head_gbus_wdata, fifo_overflow and busy are all 0.
  - A reset in mid-stream discards all queued writes; no partial output follows.
- Push: when core_gbus_wen[i]=1, {addr,data} is written into FIFO i at the posedge.
  - Address and data pass through unmodified; no decoding in this block.
- Arbitration, combinational on FIFO state:
  - Request vector req[i] = FIFO i non-empty.
  - Grant goes to the first requester at or after rr_ptr, searching upward modulo CORE_NUM.
  - On a grant to core g: pop FIFO g; rr_ptr <= (g+1) mod CORE_NUM. rr_ptr is unchanged when nothing is granted.
- Output register, updated every cycle:
  - On a grant: head_gbus_wen<=1, addr/data <= FIFO g head.
  - With no grant: head_gbus_wen<=0; addr/data are also driven to 0, never left stale.
- Latency: a write pushed at posedge t into empty FIFOs with no competition appears on head_gbus with wen=1 in the cycle after posedge t+1, i.e. 2 cycles.
- Throughput: 1 write per cycle aggregate; each core is guaranteed 1 slot per CORE_NUM cycles under full load.
- Ordering: per-core order is preserved. Order across cores is RR order only.
- Full/empty boundaries:
  - Push and pop on the same FIFO in one cycle: count unchanged. This is legal even when the FIFO is full, because the pop frees the slot.
  - Push to a full FIFO that is not popped that cycle: the write is dropped, FIFO contents are unchanged, and fifo_overflow[i]<=1.
  - A pop is only ever issued on a non-empty FIFO.
- Pointer wrap: read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- err_clear:
  - clears fifo_overflow at the posedge.
  - If an overflow occurs in the same cycle, set wins and the flag stays 1.
- busy is registered: (any count!=0 after the update) OR head_gbus_wen next value.

Decomposition:
- Shared package gbus_pkg:
  - localparams HEAD_SRAM_BIAS_WIDTH=2, BUS_CORE_ADDR_WIDTH=4, BUS_CMEM_ADDR_WIDTH=13, GBUS_DATA_WIDTH=32.
  - derived GBUS_ADDR_WIDTH.
  - packed struct gbus_wr_t {addr, data}.
- One sub-module gbus_sync_fifo (WIDTH, DEPTH):
  - ports: push, pop, din, dout, full, empty, overflow_pulse.
  - dout is the show-ahead head entry.
  - Instantiated CORE_NUM times via generate.
- RR grant logic stays inline in head_gbus_arbiter.

Test Plan:
1. Single write: core 3 wen at cycle 0 (addr=0x0_3_005, data=0xDEADBEEF) -> head_gbus_wen=1 with the same addr/data in cycle 2 only; busy 1 during cycles 1-2, then 0.
2. Simultaneous writes: all 8 cores wen at cycle 0 with data=i after reset -> outputs in cycles 2..9 carry data 0,1,...,7 in that order; no overflow.
3. RR fairness: cores 1 and 5 each push 3 writes on consecutive cycles -> output order interleaves 1,5,1,5,1,5 with no two consecutive grants to one core while the other is pending.
4. Overflow with FIFO_DEPTH=4: core 0 pushes 6 writes in consecutive cycles while cores 1-7 each hold 4 entries (forcing core 0 starvation) -> exactly the pushes that hit a full, unpopped FIFO are dropped; fifo_overflow[0]=1 and stays 1 until err_clear; other flags stay 0.
5. Full FIFO push+pop: core 2 FIFO full, granted and pushed in the same cycle -> new entry accepted, count stays 4, fifo_overflow[2] stays 0.
6. Reset mid-stream: rst=1 for 1 cycle while 10 writes are queued -> next cycle all outputs 0, busy=0, no queued write ever appears; a subsequent single push again has 2-cycle latency and core 0 RR priority.
